// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, FSM states, helpers.
package fetcher_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetcher_if.sv
// AXI-style read channel (AR/R) between the fetch stage and instruction memory.
interface fetcher_if;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;

  modport master (
    output mem_arvalid, mem_araddr, mem_rready,
    input  mem_arready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_arvalid, mem_araddr, mem_rready,
    output mem_arready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/fetcher_static_predictor.sv
// Static next-PC predictor: JAL and backward branches taken, everything else sequential.
module static_predictor
  import fetcher_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        pred,
  output logic [31:0] npc
);

  logic [31:0] j_imm;
  logic [31:0] b_imm;

  always_comb begin
    j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    pred  = 1'b0;
    npc   = pc + 32'd4;
    case (instr[6:0])
      OPC_JAL: begin
        pred = 1'b1;
        npc  = pc + j_imm;
      end
      OPC_BRANCH: begin
        if (instr[31]) begin
          pred = 1'b1;
          npc  = pc + b_imm;
        end
      end
      OPC_JALR: begin
        pred = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: owns the fetch PC, issues word reads, and presents
// {pc, instr_raw, is_jump_predicted} to decode.
module fetcher
  import fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        completed,
  output logic [31:0] pc,
  output logic [31:0] instr_raw,
  output logic        is_jump_predicted,
  fetcher_if.master   mem
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  araddr_q, araddr_d;
  logic         arvalid_q, arvalid_d;
  logic         rready_q, rready_d;
  logic         done_q, done_d;
  logic         discard_q, discard_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         pred_q, pred_d;
  logic [31:0]  redir_pc;
  logic         sp_pred;
  logic [31:0]  sp_npc;

  static_predictor u_pred (
    .pc    (araddr_q),
    .instr (mem.mem_rdata),
    .pred  (sp_pred),
    .npc   (sp_npc)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      fetch_pc_q <= word_align(RESET_PC);
      araddr_q   <= word_align(RESET_PC);
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      done_q     <= 1'b0;
      discard_q  <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      pred_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      done_q     <= done_d;
      discard_q  <= discard_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pred_q     <= pred_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    done_d     = done_q;
    discard_d  = discard_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pred_d     = pred_q;
    redir_pc   = word_align(redirect_pc);
    case (state_q)
      IDLE: begin
        if (enabled) begin
          state_d    = ADDR;
          arvalid_d  = 1'b1;
          done_d     = 1'b0;
          araddr_d   = redirect ? redir_pc : fetch_pc_q;
          fetch_pc_d = araddr_d;
        end else if (redirect) begin
          fetch_pc_d = redir_pc;
          done_d     = 1'b0;
        end
      end
      ADDR: begin
        if (redirect) begin
          discard_d  = 1'b1;
          fetch_pc_d = redir_pc;
        end
        if (mem.mem_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (mem.mem_rvalid && rready_q) begin
          rready_d = 1'b0;
          // A redirect coinciding with the response is treated as mid-flight:
          // drop the data and replay straight away at the corrected PC.
          if (discard_q || redirect) begin
            discard_d  = 1'b0;
            state_d    = ADDR;
            arvalid_d  = 1'b1;
            araddr_d   = redirect ? redir_pc : fetch_pc_q;
            fetch_pc_d = araddr_d;
          end else begin
            state_d    = IDLE;
            pc_d       = araddr_q;
            instr_d    = mem.mem_rdata;
            pred_d     = sp_pred;
            fetch_pc_d = sp_npc;
            done_d     = 1'b1;
          end
        end else if (redirect) begin
          discard_d  = 1'b1;
          fetch_pc_d = redir_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_arvalid  = arvalid_q;
  assign mem.mem_araddr   = araddr_q;
  assign mem.mem_rready   = rready_q;
  assign completed        = done_q & ~enabled;
  assign pc               = pc_q;
  assign instr_raw        = instr_q;
  assign is_jump_predicted = pred_q;

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: stimulus pushes expected AR addresses and results,
// a negedge monitor pops and compares them.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        completed;
  logic [31:0] pc;
  logic [31:0] instr_raw;
  logic        is_jump_predicted;

  fetcher_if m ();

  fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .enabled           (enabled),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .completed         (completed),
    .pc                (pc),
    .instr_raw         (instr_raw),
    .is_jump_predicted (is_jump_predicted),
    .mem               (m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } res_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_en = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int stall_obs = 0;
  int ar_stall = 0;
  int r_lat = 1;
  res_t        exp_q[$];
  logic [31:0] exp_ar[$];
  logic [31:0] mem_img [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  // Memory slave: drives arready/rvalid at negedge for the following posedge.
  initial begin : memmodel
    bit          pend = 0, last_ar = 0, last_r = 0, in_ar = 0;
    logic [31:0] paddr = '0, last_addr = '0;
    int          rcnt = 0, stall_left = 0;
    m.mem_arready = 1'b0;
    m.mem_rvalid  = 1'b0;
    m.mem_rdata   = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend = 0; last_ar = 0; last_r = 0; in_ar = 0;
        m.mem_arready = 1'b0;
        m.mem_rvalid  = 1'b0;
        continue;
      end
      if (last_ar) begin
        pend  = 1;
        paddr = last_addr;
        rcnt  = r_lat;
      end
      if (last_r) m.mem_rvalid = 1'b0;
      if (m.mem_arvalid) begin
        if (!in_ar) begin
          in_ar      = 1;
          stall_left = ar_stall;
        end
        if (stall_left > 0) begin
          m.mem_arready = 1'b0;
          stall_left--;
        end else begin
          m.mem_arready = 1'b1;
        end
      end else begin
        in_ar         = 0;
        m.mem_arready = 1'b0;
      end
      if (pend && !m.mem_rvalid) begin
        if (rcnt == 0) begin
          m.mem_rvalid = 1'b1;
          m.mem_rdata  = mem_img.exists(paddr) ? mem_img[paddr] : 32'h0000_0013;
          pend = 0;
        end else begin
          rcnt--;
        end
      end
      last_ar   = m.mem_arvalid && m.mem_arready;
      last_addr = m.mem_araddr;
      last_r    = m.mem_rvalid && m.mem_rready;
    end
  end

  // Monitor: checks AR addresses, AR stability under stall, and each new result.
  initial begin : monitor
    logic        prev_c = 0, prev_arv = 0, prev_hs = 0;
    logic [31:0] prev_addr = '0;
    res_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        if (m.mem_arvalid && prev_arv && !prev_hs)
          check32("ar_stable", m.mem_araddr, prev_addr);
        if (m.mem_arvalid && !m.mem_arready) stall_obs++;
        if (m.mem_arvalid && m.mem_arready) begin
          if (exp_ar.size() == 0) fail_now("ar_unexpected");
          else check32("araddr", m.mem_araddr, exp_ar.pop_front());
        end
        if (enabled) check1("en_while_busy", m.mem_arvalid | m.mem_rready, 1'b0);
        if (completed && !prev_c) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_q.size() == 0) begin
            fail_now("result_unexpected");
          end else begin
            e = exp_q.pop_front();
            check32("pc", pc, e.pc);
            check32("instr_raw", instr_raw, e.instr);
            check1("is_jump_predicted", is_jump_predicted, e.pred);
          end
        end
      end
      prev_c    = completed;
      prev_arv  = m.mem_arvalid;
      prev_hs   = m.mem_arvalid && m.mem_arready;
      prev_addr = m.mem_araddr;
    end
  end

  task automatic pulse_en(input logic with_redir, input logic [31:0] rpc);
    @(negedge clk);
    enabled     = 1'b1;
    redirect    = with_redir;
    redirect_pc = rpc;
    t_en        = cyc + 1;
    @(negedge clk);
    enabled  = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 60) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (done_cnt < target) fail_now(name);
  endtask

  task automatic fetch(input logic [31:0] ar, input logic [31:0] rpc_in, input logic with_redir,
                       input logic [31:0] instr, input logic pred);
    int target;
    res_t r;
    r.pc = ar; r.instr = instr; r.pred = pred;
    exp_ar.push_back(ar);
    exp_q.push_back(r);
    target = done_cnt + 1;
    pulse_en(with_redir, rpc_in);
    wait_done(target, "fetch_timeout");
  endtask

  task automatic wait_rready(input string name);
    int n = 0;
    while (!m.mem_rready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!m.mem_rready) fail_now(name);
  endtask

  task automatic check_idle_outputs(input string tag);
    check1({tag, "_completed"}, completed, 1'b0);
    check32({tag, "_pc"}, pc, 32'h0);
    check32({tag, "_instr"}, instr_raw, 32'h0);
    check1({tag, "_pred"}, is_jump_predicted, 1'b0);
    check1({tag, "_arvalid"}, m.mem_arvalid, 1'b0);
    check1({tag, "_rready"}, m.mem_rready, 1'b0);
  endtask

  initial begin : stimulus
    int s0;
    int target;
    res_t r;
    mem_img[32'h0000_0000] = 32'h0000_0013;
    mem_img[32'h0000_0100] = 32'h0080_006F;
    mem_img[32'h0000_0200] = 32'hFE00_0EE3;
    mem_img[32'h0000_01FC] = 32'h0000_0463;
    mem_img[32'h0000_0400] = 32'h0010_0093;

    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    check32("reset_araddr", m.mem_araddr, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Sequential fetch from RESET_PC, with latency and hold checks
    fetch(32'h0, 32'h0, 1'b0, 32'h0000_0013, 1'b0);
    check32("latency", 32'(done_cyc - t_en), 32'd3);
    repeat (2) @(negedge clk);
    #1;
    check1("hold_completed", completed, 1'b1);
    check32("hold_pc", pc, 32'h0);
    fetch(32'h4, 32'h0, 1'b0, 32'h0000_0013, 1'b0);

    // Redirect in IDLE clears done, then JAL +8
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check1("redir_clears_done", completed, 1'b0);
    fetch(32'h100, 32'h0, 1'b0, 32'h0080_006F, 1'b1);
    fetch(32'h108, 32'h0, 1'b0, 32'h0000_0013, 1'b0);

    // Enabled with redirect (low bits ignored), backward then forward branch
    fetch(32'h200, 32'h0000_0201, 1'b1, 32'hFE00_0EE3, 1'b1);
    fetch(32'h1FC, 32'h0, 1'b0, 32'h0000_0463, 1'b0);
    mem_img[32'h0000_0200] = 32'h0000_0463;
    fetch(32'h200, 32'h0, 1'b0, 32'h0000_0463, 1'b0);

    // Redirect while in DATA: response at 0x204 is dropped, replay at 0x400
    r_lat = 5;
    exp_ar.push_back(32'h204);
    exp_ar.push_back(32'h400);
    r.pc = 32'h400; r.instr = 32'h0010_0093; r.pred = 1'b0;
    exp_q.push_back(r);
    target = done_cnt + 1;
    pulse_en(1'b0, 32'h0);
    wait_rready("rready_timeout");
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    @(negedge clk);
    redirect = 1'b0;
    wait_done(target, "replay_timeout");
    r_lat = 1;

    // Address stall: arready low for 4 cycles
    ar_stall = 4;
    s0 = stall_obs;
    fetch(32'h404, 32'h0, 1'b0, 32'h0000_0013, 1'b0);
    check32("ar_stall_cycles", 32'(stall_obs - s0), 32'd4);
    ar_stall = 0;

    // Reset in DATA abandons the read; next fetch starts at RESET_PC
    r_lat = 5;
    exp_ar.push_back(32'h408);
    pulse_en(1'b0, 32'h0);
    wait_rready("rready_timeout2");
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rstn  = 1'b1;
    r_lat = 1;
    fetch(32'h0, 32'h0, 1'b0, 32'h0000_0013, 1'b0);

    // PC wraps from the top of the address space
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0000_0013, 1'b0);
    fetch(32'h0, 32'h0, 1'b0, 32'h0000_0013, 1'b0);

    repeat (3) @(negedge clk);
    check32("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check32("exp_ar_empty", 32'(exp_ar.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
